// File: rtl/pst_mon_pkg.sv
// Shared types and widths for the convergence monitor.
// State encoding is visible on the state output port.
package pst_mon_pkg;

    localparam int CNT_W = 16;
    localparam int ERR_W = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SETTLE    = 3'd1,
        TRACK     = 3'd2,
        CONVERGED = 3'd3,
        TIMEOUT   = 3'd4
    } state_t;

endpackage

// File: rtl/convergence_monitor_if.sv
// Bundle between the predictive layer / oscillator and the monitor.
// master drives stimulus, slave is the monitor itself.
interface convergence_monitor_if;
    import pst_mon_pkg::*;

    logic             cycle_start;
    logic [ERR_W-1:0] error_in;
    logic             enable;
    logic             restart;
    logic [2:0]       state;
    logic [CNT_W-1:0] cyc_cnt;
    logic             converged;
    logic             conv_valid;
    logic [CNT_W-1:0] conv_cycle;
    logic [ERR_W-1:0] min_err;
    logic [ERR_W-1:0] excursions;

    modport master (
        output cycle_start, error_in, enable, restart,
        input  state, cyc_cnt, converged, conv_valid,
        input  conv_cycle, min_err, excursions
    );

    modport slave (
        input  cycle_start, error_in, enable, restart,
        output state, cyc_cnt, converged, conv_valid,
        output conv_cycle, min_err, excursions
    );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// Clear and reset both return it to zero.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    // count up, hold at the ceiling
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/convergence_monitor.sv
// Watches the per-gamma-cycle prediction error and decides when the
// layer has settled (HOLD good samples in a row) or has run out of time.
module convergence_monitor
    import pst_mon_pkg::*;
#(
    parameter logic [ERR_W-1:0] CONV_TH = 8'd5,
    parameter int               HOLD    = 3,
    parameter int               SKIP    = 2,
    parameter logic [CNT_W-1:0] MAX_CYC = 16'd1000
) (
    input logic                  clk,
    input logic                  rst,
    convergence_monitor_if.slave bus
);

    localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD);
    localparam logic [CNT_W-1:0] SKIP_C = CNT_W'(SKIP);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] cyc_nx;
    logic [CNT_W-1:0] run_q;
    logic [CNT_W-1:0] run_d;
    logic [CNT_W-1:0] run_nx;
    logic [CNT_W-1:0] rs_q;
    logic [CNT_W-1:0] rs_d;
    logic [CNT_W-1:0] cc_q;
    logic [CNT_W-1:0] cc_d;
    logic [ERR_W-1:0] min_q;
    logic [ERR_W-1:0] min_d;
    logic [ERR_W-1:0] exc;
    logic             cyc_inc;
    logic             cyc_clr;
    logic             exc_inc;
    logic             exc_clr;
    logic             vld_d;
    logic             vld_q;
    logic             conv_q;
    logic             arm;
    logic             sample;
    logic             err_ok;
    logic             tracking;

    assign sample = bus.cycle_start;
    assign err_ok = (bus.error_in <= CONV_TH);
    assign cyc_nx = (cyc_cnt == '1) ? cyc_cnt : cyc_cnt + 16'd1;
    assign run_nx = (run_q >= HOLD_C) ? HOLD_C : run_q + 16'd1;

    // SETTLE with nothing left to skip behaves exactly like TRACK
    assign tracking = (state_q == TRACK) ||
                      ((state_q == SETTLE) && (cyc_cnt >= SKIP_C));

    sat_counter #(.W(CNT_W)) u_cyc (
        .clk (clk),
        .rst (rst),
        .clr (cyc_clr),
        .inc (cyc_inc),
        .q   (cyc_cnt)
    );

    sat_counter #(.W(ERR_W)) u_exc (
        .clk (clk),
        .rst (rst),
        .clr (exc_clr),
        .inc (exc_inc),
        .q   (exc)
    );

    // next state plus datapath updates for this clock
    always_comb begin
        state_d = state_q;
        arm     = 1'b0;
        cyc_inc = 1'b0;
        cyc_clr = 1'b0;
        exc_inc = 1'b0;
        exc_clr = 1'b0;
        vld_d   = 1'b0;
        run_d   = run_q;
        rs_d    = rs_q;
        min_d   = min_q;
        cc_d    = cc_q;

        if (!bus.enable) begin
            state_d = IDLE;
        end else if (bus.restart && (state_q != IDLE)) begin
            state_d = SETTLE;
            arm     = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = SETTLE;
                    arm     = 1'b1;
                end
                SETTLE: begin
                    if (tracking) begin
                        state_d = TRACK;
                    end else if (sample) begin
                        cyc_inc = 1'b1;
                        if (cyc_nx >= SKIP_C) begin
                            state_d = TRACK;
                        end
                    end
                end
                TRACK: begin
                end
                CONVERGED: begin
                    exc_inc = sample && !err_ok;
                end
                TIMEOUT: begin
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            if (tracking && sample) begin
                cyc_inc = 1'b1;
                if (bus.error_in < min_q) begin
                    min_d = bus.error_in;
                end
                if (err_ok) begin
                    run_d = run_nx;
                    if (run_q == '0) begin
                        rs_d = cyc_nx;
                    end
                end else begin
                    run_d = '0;
                end
                // a completed run beats the budget on the same sample
                if (err_ok && (run_nx >= HOLD_C)) begin
                    state_d = CONVERGED;
                    vld_d   = 1'b1;
                    cc_d    = (run_q == '0) ? cyc_nx : rs_q;
                end else if (cyc_nx >= MAX_CYC) begin
                    state_d = TIMEOUT;
                    vld_d   = 1'b1;
                    cc_d    = '0;
                end
            end
        end

        if (arm) begin
            cyc_clr = 1'b1;
            exc_clr = 1'b1;
            run_d   = '0;
            rs_d    = '0;
            min_d   = '1;
            cc_d    = '0;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // registered run tracking and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            run_q  <= '0;
            rs_q   <= '0;
            min_q  <= '1;
            cc_q   <= '0;
            vld_q  <= 1'b0;
            conv_q <= 1'b0;
        end else begin
            run_q  <= run_d;
            rs_q   <= rs_d;
            min_q  <= min_d;
            cc_q   <= cc_d;
            vld_q  <= vld_d;
            conv_q <= (state_d == CONVERGED);
        end
    end

    assign bus.state      = state_q;
    assign bus.cyc_cnt    = cyc_cnt;
    assign bus.converged  = conv_q;
    assign bus.conv_valid = vld_q;
    assign bus.conv_cycle = cc_q;
    assign bus.min_err    = min_q;
    assign bus.excursions = exc;

endmodule

// File: doc/convergence_monitor.md
CONVERGENCE_MONITOR -- requirements
Module: convergence_monitor

Interface
REQ-001 Parameter CONV_TH, default 8'd5: error at or below this value counts as a converged sample.
REQ-002 Parameter HOLD, default 3: consecutive qualifying samples needed to declare convergence.
REQ-003 Parameter SKIP, default 2: gamma cycles ignored after arm or restart.
REQ-004 Parameter MAX_CYC, default 16'd1000: cycle budget before timeout.
REQ-005 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 Port rst, input, 1: reset, synchronous, active-high.
REQ-007 Port cycle_start, input, 1: one-clock gamma-cycle strobe from the oscillator.
REQ-008 Port error_in, input, 8: L2 prediction-error magnitude from the predictive layer.
REQ-009 Port enable, input, 1: level signal; monitor runs only while this is high.
REQ-010 Port restart, input, 1: one-clock re-arm pulse, issued on a stimulus change.
REQ-011 Port state, output, 3: current FSM state.
REQ-012 Port cyc_cnt, output, 16: gamma cycles since arm or restart, counting the SKIP cycles.
REQ-013 Port converged, output, 1: level; high while in CONVERGED.
REQ-014 Port conv_valid, output, 1: one-clock pulse on entry to CONVERGED or TIMEOUT.
REQ-015 Port conv_cycle, output, 16: cyc_cnt value at the first sample of the winning run; 0 on timeout.
REQ-016 Port min_err, output, 8: minimum error_in sampled since arm.
REQ-017 Port excursions, output, 8: saturating count of samples above CONV_TH while in CONVERGED.

Function
REQ-018 FSM states: IDLE, SETTLE, TRACK, CONVERGED, TIMEOUT.
REQ-019 Sampling: error_in is sampled only on clocks where cycle_start=1; all other clocks hold state.
REQ-020 IDLE to SETTLE on enable=1; cyc_cnt cleared on entry.
REQ-021 SETTLE:
- each cycle_start increments cyc_cnt;
- error_in is ignored;
- moves to TRACK once cyc_cnt exceeds SKIP, so the first tracked sample has cyc_cnt=SKIP+1.
REQ-022 TRACK, per sample:
- cyc_cnt increments;
- min_err updates;
- error_in<=CONV_TH increments the run counter; the first sample of a run latches cyc_cnt as run_start;
- error_in>CONV_TH clears the run counter.
REQ-023 TRACK to CONVERGED when the run counter reaches HOLD:
- conv_cycle=run_start;
- conv_valid pulses;
- converged=1.
REQ-024 TRACK to TIMEOUT when cyc_cnt reaches MAX_CYC without convergence:
- conv_cycle=0;
- conv_valid pulses.
REQ-025 If the HOLD-th qualifying sample and MAX_CYC occur on the same sample, convergence wins.
REQ-026 CONVERGED:
- each sample above CONV_TH increments excursions, saturating at 255;
- the FSM stays in CONVERGED until restart, enable=0 or rst.
REQ-027 TIMEOUT holds until restart, enable=0 or rst.
REQ-028 restart=1, from any state except IDLE, on the next edge:
- clears cyc_cnt, the run counter, conv_cycle, converged and excursions;
- sets min_err=8'hFF;
- enters SETTLE.
REQ-029 restart coincident with cycle_start: restart wins and that sample is discarded.
REQ-030 enable=0 forces IDLE on the next edge; outputs hold their last values except converged, which goes to 0.
REQ-031 Counter rules:
- cyc_cnt saturates at 16'hFFFF;
- the run counter saturates at HOLD;
- no wrap-around anywhere.
REQ-032 Timing: all outputs are registered; each response appears one clock after the sampling edge.

Reset
REQ-033 Values under rst=1:
- state=IDLE;
- cyc_cnt=0, conv_cycle=0;
- converged=0, conv_valid=0;
- min_err=8'hFF;
- excursions=0;
- run counter=0.
REQ-034 rst takes priority over restart, enable and cycle_start.

Structure
REQ-035 Package pst_mon_pkg holds:
- the state enum (3-bit);
- the counter width constant (16);
- the error width constant (8).
REQ-036 One sub-module, sat_counter (parameterised width, inc/clr, saturating), is instantiated for cyc_cnt and for excursions; everything else stays in convergence_monitor.

Verification
REQ-037 Arm, SKIP=2, error_in=20,20,4,3,3 on samples 3..7 -> conv_valid on the clock after sample 7, conv_cycle=5.
REQ-038 Run broken: error_in=4,4,9,4,4,4 from sample 3 -> conv_cycle=6.
REQ-039 error_in held at 30 with MAX_CYC=10 -> TIMEOUT after cyc_cnt=10, conv_cycle=0, conv_valid pulses once.
REQ-040 While CONVERGED, error_in=12 on two samples, then restart -> excursions=2 before restart; after restart state=SETTLE, cyc_cnt=0, min_err=8'hFF.
REQ-041 restart on the same clock as cycle_start -> sample dropped and cyc_cnt=0 on the next clock.
REQ-042 rst asserted mid-TRACK with the run counter at 2 -> all REQ-033 values next clock, and no conv_valid pulse.
